// File: rtl/pps_source_selector_pkg.sv
// TimeCard_Package: shared constants for the PPS source selector.
//   - source bit positions in the 4-bit availability/active vectors
//   - PpsSourceSelect_DatIn encodings
//   - switch FSM state type
//   - target-selection helpers (fixed priority, manual override)
package TimeCard_Package;

  localparam int NUM_SRC   = 4;
  localparam int SRC_SMA   = 0;
  localparam int SRC_MAC   = 1;
  localparam int SRC_GNSS1 = 2;
  localparam int SRC_GNSS2 = 3;

  localparam logic [1:0] SEL_AUTO  = 2'b00;
  localparam logic [1:0] SEL_SMA   = 2'b01;
  localparam logic [1:0] SEL_GNSS1 = 2'b10;
  localparam logic [1:0] SEL_GNSS2 = 2'b11;

  typedef enum logic [1:0] {Idle_St, Wait_St, Switch_St} switch_st_t;

  // Fixed priority SMA > GNSS1 > GNSS2 > MAC; none available -> 0000.
  function automatic logic [NUM_SRC-1:0] auto_pick(input logic [NUM_SRC-1:0] avail);
    logic [NUM_SRC-1:0] pick;
    pick = '0;
    if (avail[SRC_SMA])        pick[SRC_SMA]   = 1'b1;
    else if (avail[SRC_GNSS1]) pick[SRC_GNSS1] = 1'b1;
    else if (avail[SRC_GNSS2]) pick[SRC_GNSS2] = 1'b1;
    else if (avail[SRC_MAC])   pick[SRC_MAC]   = 1'b1;
    return pick;
  endfunction

  // Manual choice wins only while that source is available.
  function automatic logic [NUM_SRC-1:0] sel_pick(input logic [1:0]         sel,
                                                  input logic [NUM_SRC-1:0] avail);
    logic [NUM_SRC-1:0] want;
    want = '0;
    case (sel)
      SEL_SMA:   want[SRC_SMA]   = 1'b1;
      SEL_GNSS1: want[SRC_GNSS1] = 1'b1;
      SEL_GNSS2: want[SRC_GNSS2] = 1'b1;
      default:   want            = '0;
    endcase
    return (|(want & avail)) ? want : auto_pick(avail);
  endfunction

endpackage

// File: rtl/pps_source_selector_detector.sv
// pps_available_detector: per-source PPS qualification.
//   gclk  in  : clock
//   grst  in  : asynchronous reset, active high
//   pps   in  : raw asynchronous PPS
//   lvl   out : synchronized PPS level (second sync flop)
//   avail out : source delivers in-tolerance periods
module pps_available_detector
  import TimeCard_Package::*;
#(
  parameter int ClkFreqHz_Gen    = 10000000,
  parameter int PpsTolCycles_Gen = 1000,
  parameter int GoodPulses_Gen   = 3
) (
  input  logic gclk,
  input  logic grst,
  input  logic pps,
  output logic lvl,
  output logic avail
);

  localparam int              CW   = 25;
  localparam logic [CW-1:0]   LO   = CW'(ClkFreqHz_Gen - PpsTolCycles_Gen);
  localparam logic [CW-1:0]   HI   = CW'(ClkFreqHz_Gen + PpsTolCycles_Gen);
  localparam logic [CW-1:0]   MAXC = '1;
  localparam int              GW   = $clog2(GoodPulses_Gen + 1);
  localparam logic [GW-1:0]   GMAX = GW'(GoodPulses_Gen);

  // [0] first sync flop, [1] synced level, [2] previous synced level
  logic [2:0]    sync_q;
  logic [CW-1:0] per_q;
  logic [GW-1:0] good_q;
  logic          armed_q;
  logic          avail_q;

  logic rise, in_tol, bad_evt, tmo_evt;

  assign rise    = sync_q[1] & ~sync_q[2];
  assign in_tol  = (per_q >= LO) && (per_q <= HI);
  // Unarmed edges only start timing; they are never judged.
  assign bad_evt = armed_q && rise && !in_tol;
  assign tmo_evt = armed_q && !rise && (per_q > HI);

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      sync_q  <= '0;
      per_q   <= '0;
      good_q  <= '0;
      armed_q <= 1'b0;
      avail_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], pps};

      if (rise)              per_q <= CW'(1);
      else if (per_q != MAXC) per_q <= per_q + 1'b1;

      // A timeout disarms so the next edge restarts timing from scratch.
      if (rise)         armed_q <= 1'b1;
      else if (tmo_evt) armed_q <= 1'b0;

      if (bad_evt || tmo_evt)                    good_q <= '0;
      else if (armed_q && rise && good_q != GMAX) good_q <= good_q + 1'b1;

      if (bad_evt || tmo_evt) avail_q <= 1'b0;
      else if (good_q == GMAX) avail_q <= 1'b1;
    end
  end

  assign lvl   = sync_q[1];
  assign avail = avail_q;

endmodule

// File: rtl/pps_source_selector.sv
// pps_source_selector: qualifies four PPS sources and forwards one of them.
//   SysRstN_RstIn             in  : asynchronous reset, active high
//   MhzXClk_ClkIn             in  : clock
//   Pps{Sma,Mac,Gnss1,Gnss2}_EvtIn in : raw asynchronous PPS inputs
//   PpsSourceSelect_DatIn     in  : 00 auto, 01 SMA, 10 GNSS1, 11 GNSS2
//   PpsSourceAvailable_DatOut out : availability, bit0 SMA .. bit3 GNSS2
//   PpsSelected_EvtOut        out : forwarded PPS level
//   PpsSourceActive_DatOut    out : one-hot forwarded source, 0000 = none
module pps_source_selector
  import TimeCard_Package::*;
#(
  parameter int ClkFreqHz_Gen    = 10000000,
  parameter int PpsTolCycles_Gen = 1000,
  parameter int GoodPulses_Gen   = 3
) (
  input  logic                 SysRstN_RstIn,
  input  logic                 MhzXClk_ClkIn,
  input  logic                 PpsSma_EvtIn,
  input  logic                 PpsMac_EvtIn,
  input  logic                 PpsGnss1_EvtIn,
  input  logic                 PpsGnss2_EvtIn,
  input  logic [1:0]           PpsSourceSelect_DatIn,
  output logic [NUM_SRC-1:0]   PpsSourceAvailable_DatOut,
  output logic                 PpsSelected_EvtOut,
  output logic [NUM_SRC-1:0]   PpsSourceActive_DatOut
);

  logic [NUM_SRC-1:0] pps_in, lvl, avail, target, fwd_mask;
  logic [NUM_SRC-1:0] active_q, pend_q;
  logic               out_q, load_pend;
  switch_st_t         state_q, state_d;

  assign pps_in = {PpsGnss2_EvtIn, PpsGnss1_EvtIn, PpsMac_EvtIn, PpsSma_EvtIn};

  pps_available_detector #(
    .ClkFreqHz_Gen   (ClkFreqHz_Gen),
    .PpsTolCycles_Gen(PpsTolCycles_Gen),
    .GoodPulses_Gen  (GoodPulses_Gen)
  ) u_det [NUM_SRC-1:0] (
    .gclk (MhzXClk_ClkIn),
    .grst (SysRstN_RstIn),
    .pps  (pps_in),
    .lvl  (lvl),
    .avail(avail)
  );

  assign target = sel_pick(PpsSourceSelect_DatIn, avail);

  // Switching only happens while both old and new levels are low, so the
  // output never carries a partial pulse. The target seen in that quiet cycle
  // is latched so a late target change cannot sneak in an unchecked source.
  always_comb begin
    state_d   = state_q;
    load_pend = 1'b0;
    case (state_q)
      Idle_St:   if (target != active_q) state_d = Wait_St;
      Wait_St: begin
        if (target == active_q) state_d = Idle_St;
        else if (!(|(lvl & active_q)) && !(|(lvl & target))) begin
          state_d   = Switch_St;
          load_pend = 1'b1;
        end
      end
      Switch_St: state_d = Idle_St;
      default:   state_d = Idle_St;
    endcase
  end

  // During Switch_St the new source is already forwarded: it was low in the
  // quiet cycle, so any pulse it starts now is shown from its first cycle.
  assign fwd_mask = (state_q == Switch_St) ? pend_q : active_q;

  always_ff @(posedge MhzXClk_ClkIn or posedge SysRstN_RstIn) begin
    if (SysRstN_RstIn) begin
      state_q  <= Idle_St;
      active_q <= '0;
      pend_q   <= '0;
      out_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_pend)              pend_q   <= target;
      if (state_q == Switch_St)   active_q <= pend_q;
      out_q <= |(lvl & fwd_mask);
    end
  end

  assign PpsSourceAvailable_DatOut = avail;
  assign PpsSourceActive_DatOut    = active_q;
  assign PpsSelected_EvtOut        = out_q;

endmodule

// File: tb/tb_pps_source_selector.sv
module tb_pps_source_selector;

  localparam int F = 1000;
  localparam int T = 10;
  localparam int G = 3;
  localparam int W = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pps_v = '0;
  logic [1:0] sel = 2'b00;
  logic [3:0] avail, active;
  logic       out;

  int vectors = 0;
  int miscompares = 0;

  bit en  [4] = '{default: 1'b0};
  int per [4] = '{default: F};
  int ph  [4] = '{default: 0};
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  pps_source_selector #(
    .ClkFreqHz_Gen   (F),
    .PpsTolCycles_Gen(T),
    .GoodPulses_Gen  (G)
  ) dut (
    .SysRstN_RstIn            (rst),
    .MhzXClk_ClkIn            (clk),
    .PpsSma_EvtIn             (pps_v[0]),
    .PpsMac_EvtIn             (pps_v[1]),
    .PpsGnss1_EvtIn           (pps_v[2]),
    .PpsGnss2_EvtIn           (pps_v[3]),
    .PpsSourceSelect_DatIn    (sel),
    .PpsSourceAvailable_DatOut(avail),
    .PpsSelected_EvtOut       (out),
    .PpsSourceActive_DatOut   (active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge right after the cycle in which source i rose.
  task automatic wait_rise(input int i);
    int n;
    n = 0;
    while (pps_v[i] && n < 3000) begin @(negedge clk); n++; end
    while (!pps_v[i] && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      vectors++;
      miscompares++;
      $error("FAIL wait_rise src%0d: observed no edge expected edge within 3000 cycles", i);
    end
  endtask

  // Pulse generators: period per[i], width W, phase counter ph[i].
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (en[i]) begin
          ph[i]    = (ph[i] + 1 >= per[i]) ? 0 : ph[i] + 1;
          pps_v[i] = (ph[i] < W);
        end else begin
          pps_v[i] = 1'b0;
        end
      end
    end
  end

  // Every completed output pulse must be a full-width source pulse.
  bit prev_out = 1'b0;
  bit trk = 1'b0;
  int wcnt = 0;
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      trk = 1'b0;
      wcnt = 0;
    end else if (out) begin
      if (!prev_out) begin trk = 1'b1; wcnt = 0; end
      wcnt++;
    end else if (prev_out && trk) begin
      chk("out_pulse_width", wcnt, W);
      trk = 1'b0;
    end
    prev_out = out;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    cyc(3);
    chk("rst_avail", avail, 4'b0000);
    chk("rst_active", active, 4'b0000);
    chk("rst_out", out, 1'b0);
    rst = 1'b0;
    mon_en = 1'b1;
    cyc(2);

    // SMA at 0, GNSS1 +300, GNSS2 +600, all period 1000; MAC silent
    ph[0] = F - 1;   en[0] = 1'b1;
    ph[2] = F - 301; en[2] = 1'b1;
    ph[3] = F - 601; en[3] = 1'b1;
    wait_rise(0); wait_rise(0); wait_rise(0);
    wait_rise(0);
    cyc(3); chk("sma_q_pre", avail[0], 1'b0);
    cyc(1); chk("sma_q_post", avail[0], 1'b1);
    wait_rise(0);
    chk("a_avail", avail, 4'b1101);
    chk("a_active", active, 4'b0001);
    cyc(2); chk("a_lat_pre", out, 1'b0);
    cyc(1); chk("a_lat_post", out, 1'b1);

    // Select toggles while SMA is high: one Wait, no change of active
    cyc(2); sel = 2'b10;
    cyc(3); chk("tog_act1", active, 4'b0001); sel = 2'b11;
    cyc(3); chk("tog_act2", active, 4'b0001); sel = 2'b10;
    cyc(10); chk("tog_act3", active, 4'b0001);
    chk("tog_out", out, 1'b1);
    cyc(179); chk("g1_manual", active, 4'b0100);   // k+200
    sel = 2'b11;
    cyc(50); chk("g2_manual", active, 4'b1000);    // k+250
    en[3] = 1'b0;
    cyc(650); chk("g2_lost_act", active, 4'b0001); // k+900
    chk("g2_lost_avail", avail, 4'b0101);
    sel = 2'b00;

    // SMA stops: timeout then fall back to GNSS1
    wait_rise(0);
    cyc(3); chk("c_out", out, 1'b1);
    cyc(147); en[0] = 1'b0;
    cyc(855); chk("tmo_pre", avail, 4'b0101);
    cyc(15);  chk("tmo_post", avail, 4'b0100);
    cyc(80);  chk("c_active", active, 4'b0100);
    wait_rise(2);
    cyc(2); chk("g1_lat_pre", out, 1'b0);
    cyc(1); chk("g1_lat_post", out, 1'b1);

    // SMA back, then periods 1010 (good) and 1011 (bad)
    cyc(200);
    per[0] = F; ph[0] = F - 1; en[0] = 1'b1;
    wait_rise(0); wait_rise(0); wait_rise(0);
    wait_rise(0);
    cyc(3); chk("d_q_pre", avail, 4'b0100);
    cyc(1); chk("d_q_post", avail, 4'b0101);
    wait_rise(0);
    chk("d_active", active, 4'b0001);
    per[0] = F + T;
    wait_rise(0);
    cyc(5); chk("per1010", avail, 4'b0101);
    per[0] = F + T + 1;
    wait_rise(0);
    cyc(2); chk("per1011_pre", avail, 4'b0101);
    cyc(1); chk("per1011_post", avail, 4'b0100);
    cyc(257); chk("d_fallback", active, 4'b0100);
    en[0] = 1'b0;

    // Reset during a forwarded high pulse
    wait_rise(2);
    cyc(50); chk("e_out_hi", out, 1'b1);
    rst = 1'b1;
    #1;
    chk("e_rst_out", out, 1'b0);
    chk("e_rst_avail", avail, 4'b0000);
    chk("e_rst_active", active, 4'b0000);
    cyc(80);
    chk("e_rst_hold", out, 1'b0);
    rst = 1'b0;
    wait_rise(2); wait_rise(2); wait_rise(2);
    cyc(5); chk("e_q3", avail, 4'b0000);
    wait_rise(2);
    cyc(3); chk("e_q4_pre", avail, 4'b0000);
    cyc(1); chk("e_q4_post", avail, 4'b0100);
    cyc(200); chk("e_active", active, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
